// File: rtl/row_pack_8x_pkg.sv
// Shared constants for the 8x8 block front end (row packer and transpose stage).
// Block geometry, counter width and default pixel width live here so both
// stages agree on them.
package row_pack_8x_pkg;

    localparam int PIX_PER_ROW  = 8;
    localparam int ROWS_PER_BLK = 8;
    localparam int CNT_W        = 3;
    localparam int BW_DEFAULT   = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAST_PIX = cnt_t'(PIX_PER_ROW - 1);
    localparam cnt_t LAST_ROW = cnt_t'(ROWS_PER_BLK - 1);

endpackage

// File: rtl/row_pack_8x.sv
// row_pack_8x: collects a raster stream of pixels into packed 8-pixel rows for
// the downstream transpose stage. Pixel 0 of a row lands in the MSB slice of
// o_data. o_en pulses one cycle after the 8th pixel of each row, o_eob marks
// the last row of an 8x8 block, o_err flags a start-of-frame that arrived
// mid-block (the partial block is dropped and the sof pixel starts a new one).
//
// Build option: define ROW_PACK_LEVEL_SHIFT_EN to level-shift every pixel by
// -2^(BW-1) (unsigned -> two's complement, i.e. MSB inverted) before packing.
// Latency is the same with or without the option.
module row_pack_8x
    import row_pack_8x_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_Reset,
    input  logic [BW-1:0]             i_pixel,
    input  logic                      i_valid,
    input  logic                      i_sof,
    output logic [PIX_PER_ROW*BW-1:0] o_data,
    output logic                      o_en,
    output logic                      o_eob,
    output logic                      o_err
);

    localparam int            HOLD_W   = (PIX_PER_ROW - 1) * BW;
    localparam logic [BW-1:0] MSB_MASK = BW'(1) << (BW - 1);

    // Optional level shift; subtracting 2^(BW-1) modulo 2^BW only flips the MSB.
    function automatic logic [BW-1:0] level_shift(input logic [BW-1:0] pix);
`ifdef ROW_PACK_LEVEL_SHIFT_EN
        return pix ^ MSB_MASK;
`else
        return pix;
`endif
    endfunction

    cnt_t                pix_cnt;
    cnt_t                row_cnt;
    logic [HOLD_W-1:0]   hold_p0;
    logic [BW-1:0]       pix_p0;
    logic                resync;
    logic                row_done;
    logic                last_row;

    // Stage 0: incoming pixel, framing decisions for this edge
    always_comb begin
        pix_p0   = level_shift(i_pixel);
        resync   = i_valid && i_sof && ((pix_cnt != '0) || (row_cnt != '0));
        row_done = i_valid && !resync && (pix_cnt == LAST_PIX);
        last_row = (row_cnt == LAST_ROW);
    end

    // Pixel and row counters; a mid-block sof restarts at pixel 1 of row 0
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            pix_cnt <= '0;
            row_cnt <= '0;
        end else if (resync) begin
            pix_cnt <= cnt_t'(1);
            row_cnt <= '0;
        end else if (i_valid) begin
            pix_cnt <= pix_cnt + cnt_t'(1);
            if (pix_cnt == LAST_PIX) begin
                row_cnt <= row_cnt + cnt_t'(1);
            end
        end
    end

    // Holding shift register for the first seven pixels of the current row;
    // stale pixels of a finished row shift out as the next row fills it
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            hold_p0 <= '0;
        end else if (resync) begin
            hold_p0 <= HOLD_W'(pix_p0);
        end else if (i_valid) begin
            hold_p0 <= {hold_p0[HOLD_W-BW-1:0], pix_p0};
        end
    end

    // Stage 1: registered row output and status pulses; o_data holds between rows
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            o_data <= '0;
            o_en   <= 1'b0;
            o_eob  <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            o_en  <= row_done;
            o_eob <= row_done && last_row;
            o_err <= resync;
            if (row_done) begin
                o_data <= {hold_p0, pix_p0};
            end
        end
    end

endmodule

// File: tb/tb_row_pack_8x.sv
// Bench for row_pack_8x at BW=8: a queue-based model of the row packing rules
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_row_pack_8x;

    localparam int BW = 8;

    logic          i_clk   = 1'b0;
    logic          i_Reset = 1'b0;
    logic [BW-1:0] i_pixel = '0;
    logic          i_valid = 1'b0;
    logic          i_sof   = 1'b0;
    logic [63:0]   o_data;
    logic          o_en;
    logic          o_eob;
    logic          o_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    row_pack_8x #(.BW(BW)) dut (
        .i_clk   (i_clk),
        .i_Reset (i_Reset),
        .i_pixel (i_pixel),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .o_data  (o_data),
        .o_en    (o_en),
        .o_eob   (o_eob),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    // Expected packed row for a literal, accounting for the build option
    function automatic logic [63:0] xf(input logic [63:0] v);
`ifdef ROW_PACK_LEVEL_SHIFT_EN
        return v ^ {8{8'h80}};
`else
        return v;
`endif
    endfunction

    function automatic logic [BW-1:0] model_pix(input logic [BW-1:0] p);
`ifdef ROW_PACK_LEVEL_SHIFT_EN
        return p - BW'(1 << (BW - 1));
`else
        return p;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: pixels of the current row in a queue, row index within the block
    logic [BW-1:0] row_q[$];
    int            row_idx = 0;
    logic [63:0]   m_data  = '0;
    logic          m_en    = 1'b0;
    logic          m_eob   = 1'b0;
    logic          m_err   = 1'b0;

    always @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            row_q.delete();
            row_idx = 0;
            m_data  = '0;
            m_en    = 1'b0;
            m_eob   = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_en  = 1'b0;
            m_eob = 1'b0;
            m_err = 1'b0;
            if (i_valid) begin
                if (i_sof && (row_q.size() != 0 || row_idx != 0)) begin
                    row_q.delete();
                    row_idx = 0;
                    m_err   = 1'b1;
                end
                row_q.push_back(model_pix(i_pixel));
                if (row_q.size() == 8) begin
                    for (int k = 0; k < 8; k++) m_data[(8-k)*BW-1 -: BW] = row_q[k];
                    m_en    = 1'b1;
                    m_eob   = (row_idx == 7);
                    row_idx = (row_idx + 1) % 8;
                    row_q.delete();
                end
            end
        end
    end

    // Per-cycle comparison plus event bookkeeping for the literal checks
    int          en_cnt  = 0;
    int          eob_cnt = 0;
    int          err_cnt = 0;
    int          eob_cyc = 0;
    logic [63:0] last_data = '0;
    int          en_cycs[$];

    always @(negedge i_clk) begin
        chk("o_en",   64'(o_en),  64'(m_en));
        chk("o_eob",  64'(o_eob), 64'(m_eob));
        chk("o_err",  64'(o_err), 64'(m_err));
        chk("o_data", o_data, m_data);
        if (o_en) begin
            en_cnt++;
            last_data = o_data;
            en_cycs.push_back(cyc);
        end
        if (o_eob) begin
            eob_cnt++;
            eob_cyc = cyc;
        end
        if (o_err) err_cnt++;
    end

    task automatic send(input logic [BW-1:0] px, input logic sof);
        @(posedge i_clk);
        #2;
        i_valid = 1'b1;
        i_pixel = px;
        i_sof   = sof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
            i_valid = 1'b0;
            i_sof   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #2;
        i_Reset = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        #1;
        chk("rst_o_data", o_data, 64'h0);
        chk("rst_o_en",   64'(o_en),  64'h0);
        chk("rst_o_eob",  64'(o_eob), 64'h0);
        chk("rst_o_err",  64'(o_err), 64'h0);
        repeat (2) @(posedge i_clk);
        #2;
        i_Reset = 1'b1;
    endtask

    int s_en, s_eob, s_err, start, d1;

    task automatic snap();
        s_en  = en_cnt;
        s_eob = eob_cnt;
        s_err = err_cnt;
    endtask

    task automatic full_block(input logic extra_sof);
        do_reset();
        snap();
        for (int i = 0; i < 64; i++) send(BW'(8'h40 + i), (i == 0));
        if (extra_sof) send(8'h55, 1'b1);
        idle(3);
        chk("blk_en_count",  64'(en_cnt - s_en),   64'd8);
        chk("blk_eob_count", 64'(eob_cnt - s_eob), 64'd1);
        chk("blk_err_count", 64'(err_cnt - s_err), 64'd0);
        for (int j = 1; j < 8; j++)
            chk("blk_en_spacing",
                64'(en_cycs[en_cycs.size()-8+j] - en_cycs[en_cycs.size()-9+j]), 64'd8);
        chk("blk_eob_on_last", 64'(eob_cyc), 64'(en_cycs[en_cycs.size()-1]));
    endtask

    initial begin
        // Single row, continuous
        do_reset();
        snap();
        send(8'h01, 1'b0);
        start = cyc;
        for (int i = 2; i <= 8; i++) send(BW'(i), 1'b0);
        idle(3);
        chk("row_en_count", 64'(en_cnt - s_en), 64'd1);
        chk("row_data", last_data, xf(64'h0102030405060708));
        d1 = en_cycs[en_cycs.size()-1] - start;
        chk("row_latency", 64'(d1), 64'd8);

        // Full block with sof on the first pixel
        full_block(1'b0);

        // Same row with a 3-cycle gap after pixel 4
        do_reset();
        snap();
        send(8'h01, 1'b0);
        start = cyc;
        for (int i = 2; i <= 4; i++) send(BW'(i), 1'b0);
        idle(3);
        for (int i = 5; i <= 8; i++) send(BW'(i), 1'b0);
        idle(3);
        chk("gap_en_count", 64'(en_cnt - s_en), 64'd1);
        chk("gap_data", last_data, xf(64'h0102030405060708));
        chk("gap_latency", 64'(en_cycs[en_cycs.size()-1] - start), 64'(d1 + 3));

        // sof on the 4th pixel of a row
        do_reset();
        snap();
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        send(8'h14, 1'b1);
        for (int i = 5; i <= 11; i++) send(BW'(8'h10 + i), 1'b0);
        idle(3);
        chk("sof_err_count", 64'(err_cnt - s_err), 64'd1);
        chk("sof_en_count",  64'(en_cnt - s_en),   64'd1);
        chk("sof_data", last_data, xf(64'h1415161718191A1B));

        // Reset mid-row, then a fresh row
        do_reset();
        for (int i = 1; i <= 8; i++) send(BW'(i), 1'b0);
        for (int i = 1; i <= 5; i++) send(BW'(8'h30 + i), 1'b0);
        idle(1);
        chk("pre_rst_data", o_data, xf(64'h0102030405060708));
        do_reset();
        snap();
        for (int i = 0; i < 8; i++) send(BW'(8'hA0 + i), 1'b0);
        idle(3);
        chk("rst_mid_en_count", 64'(en_cnt - s_en), 64'd1);
        chk("rst_mid_data", last_data, xf(64'hA0A1A2A3A4A5A6A7));

        // Block end followed directly by sof
        full_block(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
